// File: rtl/var_par_circular_buffer_pkg.sv
// Shared types, widths and helpers for the variable-parallel circular buffer.
// The widths below describe the default build (DEPTH=32, PAR_WRITE=PAR_READ=4).
package var_par_circular_buffer_pkg;

   localparam int DEF_DEPTH     = 32;
   localparam int DEF_PAR_WRITE = 4;
   localparam int DEF_PAR_READ  = 4;

   localparam int PTR_W  = (DEF_DEPTH > 1) ? $clog2(DEF_DEPTH) : 1;
   localparam int OCC_W  = $clog2(DEF_DEPTH + 1);
   localparam int WCNT_W = $clog2(DEF_PAR_WRITE + 1);
   localparam int RCNT_W = $clog2(DEF_PAR_READ + 1);

   // Modulo-depth add. Both operands are below depth, so one subtract suffices.
   function automatic logic [31:0] ptr_add(
      input logic [31:0] p,
      input logic [31:0] n,
      input logic [31:0] depth
   );
      logic [31:0] sum;
      sum = p + n;
      if (sum >= depth) begin
         sum = sum - depth;
      end
      return sum;
   endfunction

endpackage

// File: rtl/var_par_circular_buffer_circ_ptr_reg.sv
// Circular pointer register: advances by a variable count modulo DEPTH.
// Used for both the write and read pointers of the buffer.
module circ_ptr_reg
   import var_par_circular_buffer_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int PTR_W = 5,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             adv_en,
   input  logic [CNT_W-1:0] adv_cnt,
   output logic [PTR_W-1:0] ptr
);

   localparam logic [31:0] DEPTH_U = 32'(DEPTH);

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;

   // Next pointer: wrap the advance around the buffer depth.
   always_comb begin
      ptr_d = ptr_q;
      if (adv_en) begin
         ptr_d = PTR_W'(ptr_add(32'(ptr_q), 32'(adv_cnt), DEPTH_U));
      end
   end

   // Pointer register with synchronous reset to slot 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/var_par_circular_buffer.sv
// Parallel circular buffer: writes 0..PAR_WRITE and reads 0..PAR_READ rows per
// cycle, with an occupancy counter so every one of the DEPTH slots is usable.
module var_par_circular_buffer
   import var_par_circular_buffer_pkg::*;
#(
   parameter int ROW_SIZE  = 8,
   parameter int DEPTH     = 32,
   parameter int PAR_WRITE = 4,
   parameter int PAR_READ  = 4,
   parameter int AF_THRESH = DEPTH - PAR_WRITE,
   parameter int AE_THRESH = PAR_READ - 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              wr_valid,
   input  logic [$clog2(PAR_WRITE+1)-1:0]    wr_count,
   input  logic [ROW_SIZE*PAR_WRITE-1:0]     din,
   output logic                              wr_ready,
   input  logic                              rd_ready,
   input  logic [$clog2(PAR_READ+1)-1:0]     rd_count,
   output logic [ROW_SIZE*PAR_READ-1:0]      dout,
   output logic                              rd_valid,
   output logic [$clog2(DEPTH+1)-1:0]        occupancy,
   output logic                              almost_full,
   output logic                              almost_empty
);

   localparam int L_PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int L_OCC_W  = $clog2(DEPTH + 1);
   localparam int L_WCNT_W = $clog2(PAR_WRITE + 1);
   localparam int L_RCNT_W = $clog2(PAR_READ + 1);

   localparam logic [31:0] DEPTH_U = 32'(DEPTH);
   localparam logic [31:0] PW_U    = 32'(PAR_WRITE);
   localparam logic [31:0] PR_U    = 32'(PAR_READ);
   localparam logic [31:0] AF_U    = 32'(AF_THRESH);
   localparam logic [31:0] AE_U    = 32'(AE_THRESH);

   logic [ROW_SIZE-1:0] mem_q [DEPTH];
   logic [ROW_SIZE-1:0] mem_d [DEPTH];
   logic [L_OCC_W-1:0]  occ_q;
   logic [L_OCC_W-1:0]  occ_d;
   logic [L_PTR_W-1:0]  wptr;
   logic [L_PTR_W-1:0]  rptr;
   logic [31:0]         wc;
   logic [31:0]         rc;
   logic [31:0]         oc;
   logic [31:0]         nrd;
   logic                acc_w;
   logic                acc_r;

   assign wc = 32'(wr_count);
   assign rc = 32'(rd_count);
   assign oc = 32'(occ_q);

   // Handshakes and occupancy update; both sides see start-of-cycle occupancy.
   always_comb begin
      wr_ready = (wc <= PW_U) && (wc <= DEPTH_U - oc);
      rd_valid = (rc != 32'd0) && (rc <= PR_U) && (rc <= oc);
      acc_w    = wr_valid && wr_ready && (wc != 32'd0);
      acc_r    = rd_valid && rd_ready;
      occ_d    = L_OCC_W'(oc + (acc_w ? wc : 32'd0)
                             - (acc_r ? rc : 32'd0));
   end

   // Occupancy register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   circ_ptr_reg #(
      .DEPTH (DEPTH),
      .PTR_W (L_PTR_W),
      .CNT_W (L_WCNT_W)
   ) u_wptr (
      .clk     (clk),
      .rst     (rst),
      .adv_en  (acc_w),
      .adv_cnt (wr_count),
      .ptr     (wptr)
   );

   circ_ptr_reg #(
      .DEPTH (DEPTH),
      .PTR_W (L_PTR_W),
      .CNT_W (L_RCNT_W)
   ) u_rptr (
      .clk     (clk),
      .rst     (rst),
      .adv_en  (acc_r),
      .adv_cnt (rd_count),
      .ptr     (rptr)
   );

   // Scatter the accepted write lanes to consecutive slots after wptr.
   always_comb begin
      mem_d = mem_q;
      for (int i = 0; i < PAR_WRITE; i++) begin
         if (acc_w && (32'(i) < wc)) begin
            mem_d[L_PTR_W'(ptr_add(32'(wptr), 32'(i), DEPTH_U))] =
               din[i*ROW_SIZE +: ROW_SIZE];
         end
      end
   end

   // Storage holds its contents across reset; only pointers are cleared.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Gather the oldest rows onto the read lanes; unrequested lanes read zero.
   always_comb begin
      nrd  = (rc < oc) ? rc : oc;
      dout = '0;
      for (int i = 0; i < PAR_READ; i++) begin
         if (32'(i) < nrd) begin
            dout[i*ROW_SIZE +: ROW_SIZE] =
               mem_q[L_PTR_W'(ptr_add(32'(rptr), 32'(i), DEPTH_U))];
         end
      end
   end

   assign occupancy    = occ_q;
   assign almost_full  = (oc >= AF_U);
   assign almost_empty = (oc <= AE_U);

endmodule
